ddr_cmd_slot_sched: RTL

- Sits between the request front-end (decoded single DDR commands) and the scheduler-to-PHY converter.
- Packs at most one DDR command per fabric cycle into one of the 4 DRAM-clock slots of the 4:1 command word.
- Enforces a per-command minimum gap, in nCK, to the next command, and keeps READ/WRITE in odd slots (1 or 3), as the converter's CAS-slot encoding requires.
- Injects periodic refresh (PREA, then REF) with priority over the requester.

---
 rtl/ddr_cmd_slot_sched_if.sv | 38 +++
 rtl/ddr_cmd_slot_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_slot_sched_if.sv
// Request/issue bus between the DDR command front-end and the 4:1 slot scheduler.
// Field widths come from the DEC_DDR_CMD_SZ / ROW_SZ / BANK_SZ / COL_SZ macros.
`ifndef DEC_DDR_CMD_SZ
`define DEC_DDR_CMD_SZ 7
`endif
`ifndef ROW_SZ
`define ROW_SZ 15
`endif
`ifndef BANK_SZ
`define BANK_SZ 3
`endif
`ifndef COL_SZ
`define COL_SZ 10
`endif

interface ddr_cmd_slot_sched_if;
    logic                            req_valid;
    logic                            req_ready;
    logic [`DEC_DDR_CMD_SZ-1:0]      req_cmd;
    logic [`ROW_SZ-1:0]              req_row;
    logic [`BANK_SZ-1:0]             req_bank;
    logic [`COL_SZ-1:0]              req_col;
    logic [7:0]                      req_gap;
    logic [`DEC_DDR_CMD_SZ*4-1:0]    scd_cmd;
    logic [`ROW_SZ*4-1:0]            scd_row;
    logic [`BANK_SZ*4-1:0]           scd_bank;
    logic [`COL_SZ*4-1:0]            scd_col;

    modport master (
        output req_valid, req_cmd, req_row, req_bank, req_col, req_gap,
        input  req_ready, scd_cmd, scd_row, scd_bank, scd_col
    );

    modport slave (
        input  req_valid, req_cmd, req_row, req_bank, req_col, req_gap,
        output req_ready, scd_cmd, scd_row, scd_bank, scd_col
    );
endinterface

// File: rtl/ddr_cmd_slot_sched.sv
// Packs one DDR command per fabric cycle into a 4-slot command word, honouring nCK gaps,
// odd CAS slots and periodic PREA+REF refresh. Define ZQS_AFTER_REF_EN to follow REF with ZQS.
`ifndef DEC_DDR_CMD_SZ
`define DEC_DDR_CMD_SZ 7
`endif
`ifndef ROW_SZ
`define ROW_SZ 15
`endif
`ifndef BANK_SZ
`define BANK_SZ 3
`endif
`ifndef COL_SZ
`define COL_SZ 10
`endif

module ddr_cmd_slot_sched #(
    parameter int T_REFI_CYC = 1950,
    parameter int T_RP       = 11,
    parameter int T_RFC      = 208,
    parameter int T_ZQCS     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init_calib_complete,
    input  logic                       phy_mc_cmd_full,
    ddr_cmd_slot_sched_if.slave        bus,
    output logic                       ref_busy
);

    localparam int CW     = `DEC_DDR_CMD_SZ;
    localparam int RW     = `ROW_SZ;
    localparam int BW     = `BANK_SZ;
    localparam int LW     = `COL_SZ;
    localparam int REFI_W = $clog2(T_REFI_CYC + 1);

    localparam logic [REFI_W-1:0] REFI_RELOAD = REFI_W'(T_REFI_CYC - 1);
    localparam logic [7:0]        GAP_RP      = 8'(T_RP);
    localparam logic [7:0]        GAP_RFC     = 8'(T_RFC);
    localparam logic [7:0]        GAP_ZQCS    = 8'(T_ZQCS);

    localparam logic [CW-1:0] CMD_ZQS  = CW'(7'b001_0000);
    localparam logic [CW-1:0] CMD_REF  = CW'(7'b010_0000);
    localparam logic [CW-1:0] CMD_PREA = CW'(7'b100_0000);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PREA = 2'd1,
        ST_REF  = 2'd2,
        ST_ZQ   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [8:0]          nck_wait_q, nck_wait_d;
    logic [REFI_W-1:0]   refi_cnt_q, refi_cnt_d;
    logic                ref_pending_q, ref_pending_d;
    logic [CW*4-1:0]     scd_cmd_q, scd_cmd_d;
    logic [RW*4-1:0]     scd_row_q, scd_row_d;
    logic [BW*4-1:0]     scd_bank_q, scd_bank_d;
    logic [LW*4-1:0]     scd_col_q, scd_col_d;

    logic                run_ok;
    logic                legal;
    logic                ready_c;
    logic                issue;
    logic                is_cas;
    logic                no_addr;
    logic                pend_set;
    logic                pend_clr;
    logic [CW-1:0]       iss_cmd;
    logic [RW-1:0]       iss_row;
    logic [BW-1:0]       iss_bank;
    logic [LW-1:0]       iss_col;
    logic [7:0]          iss_gap;
    logic [7:0]          gap_eff;
    logic [1:0]          iss_slot;
    logic [9:0]          wait_sum;

    // Issue selection: refresh states own the slot, otherwise the requester may issue.
    always_comb begin
        run_ok   = init_calib_complete && !phy_mc_cmd_full;
        legal    = (nck_wait_q < 9'd4);
        ready_c  = run_ok && (state_q == ST_RUN) && !ref_pending_q && legal;
        issue    = 1'b0;
        iss_cmd  = '0;
        iss_row  = '0;
        iss_bank = '0;
        iss_col  = '0;
        iss_gap  = 8'd0;
        if (run_ok && legal) begin
            case (state_q)
                ST_RUN: begin
                    if (!ref_pending_q && bus.req_valid) begin
                        issue    = 1'b1;
                        iss_cmd  = bus.req_cmd;
                        iss_row  = bus.req_row;
                        iss_bank = bus.req_bank;
                        iss_col  = bus.req_col;
                        iss_gap  = bus.req_gap;
                    end
                end
                ST_PREA: begin
                    issue   = 1'b1;
                    iss_cmd = CMD_PREA;
                    iss_gap = GAP_RP;
                end
                ST_REF: begin
                    issue   = 1'b1;
                    iss_cmd = CMD_REF;
                    iss_gap = GAP_RFC;
                end
                ST_ZQ: begin
                    issue   = 1'b1;
                    iss_cmd = CMD_ZQS;
                    iss_gap = GAP_ZQCS;
                end
                default: ;
            endcase
        end
        // Bank-wide maintenance commands carry no address, even when the requester supplies one.
        no_addr = |(iss_cmd & (CMD_ZQS | CMD_REF | CMD_PREA));
        if (no_addr) begin
            iss_row  = '0;
            iss_bank = '0;
            iss_col  = '0;
        end
    end

    // CAS commands are pushed to the next odd slot for the converter's CAS-slot encoding.
    always_comb begin
        is_cas   = iss_cmd[2] || iss_cmd[3];
        iss_slot = is_cas ? (nck_wait_q[1:0] | 2'b01) : nck_wait_q[1:0];
        gap_eff  = (iss_gap == 8'd0) ? 8'd1 : iss_gap;
        wait_sum = {8'd0, iss_slot} + {2'd0, gap_eff};
    end

    always_comb begin
        nck_wait_d = nck_wait_q;
        if (!init_calib_complete) begin
            nck_wait_d = 9'd0;
        end else if (!phy_mc_cmd_full) begin
            if (issue) begin
                nck_wait_d = (wait_sum > 10'd4) ? 9'(wait_sum - 10'd4) : 9'd0;
            end else begin
                nck_wait_d = (nck_wait_q >= 9'd4) ? (nck_wait_q - 9'd4) : 9'd0;
            end
        end
    end

    // Refresh interval counter keeps running under backpressure; only calibration stalls it.
    always_comb begin
        pend_set   = 1'b0;
        refi_cnt_d = refi_cnt_q;
        if (!init_calib_complete) begin
            refi_cnt_d = REFI_RELOAD;
        end else if (refi_cnt_q == '0) begin
            refi_cnt_d = REFI_RELOAD;
            pend_set   = 1'b1;
        end else begin
            refi_cnt_d = refi_cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        pend_clr = 1'b0;
        if (run_ok) begin
            case (state_q)
                ST_RUN: begin
                    if (ref_pending_q) state_d = ST_PREA;
                end
                ST_PREA: begin
                    if (issue) begin
                        state_d  = ST_REF;
                        pend_clr = 1'b1;
                    end
                end
                ST_REF: begin
`ifdef ZQS_AFTER_REF_EN
                    if (issue) state_d = ST_ZQ;
`else
                    if (issue) state_d = ST_RUN;
`endif
                end
                ST_ZQ: begin
                    if (issue) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
        ref_pending_d = (ref_pending_q && !pend_clr) || pend_set;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            logic hit;
            assign hit = issue && (iss_slot == 2'(gi));
            assign scd_cmd_d[gi*CW +: CW]  = hit ? iss_cmd  : '0;
            assign scd_row_d[gi*RW +: RW]  = hit ? iss_row  : '0;
            assign scd_bank_d[gi*BW +: BW] = hit ? iss_bank : '0;
            assign scd_col_d[gi*LW +: LW]  = hit ? iss_col  : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            nck_wait_q    <= 9'd0;
            refi_cnt_q    <= REFI_RELOAD;
            ref_pending_q <= 1'b0;
            scd_cmd_q     <= '0;
            scd_row_q     <= '0;
            scd_bank_q    <= '0;
            scd_col_q     <= '0;
        end else begin
            state_q       <= state_d;
            nck_wait_q    <= nck_wait_d;
            refi_cnt_q    <= refi_cnt_d;
            ref_pending_q <= ref_pending_d;
            scd_cmd_q     <= scd_cmd_d;
            scd_row_q     <= scd_row_d;
            scd_bank_q    <= scd_bank_d;
            scd_col_q     <= scd_col_d;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.scd_cmd   = scd_cmd_q;
    assign bus.scd_row   = scd_row_q;
    assign bus.scd_bank  = scd_bank_q;
    assign bus.scd_col   = scd_col_q;
    assign ref_busy      = ref_pending_q || (state_q != ST_RUN);

endmodule
